// File: rtl/decode_unit.sv
// decode_unit: RV32I instruction decode stage.
// Classifies each instruction word, extracts the sign-extended immediate,
// register/funct fields and the PC-increment operation, and holds the result
// in a two-entry (main + skid) buffer so one instruction per cycle is sustained
// under backpressure. All outputs are registered.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   - invalid instructions are flagged (o_illegal=1, pc op = hold) and,
//               once delivered, the stage halts until reset.
//   undefined - invalid instructions pass through as type 7 NOPs; no halt state.
module decode_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_instr_valid,
  output logic            o_instr_ready,
  input  logic [XLEN-1:0] i_instr_data,
  output logic            o_dec_valid,
  input  logic            i_dec_ready,
  output logic [2:0]      o_instr_type,
  output logic [XLEN-1:0] o_imm_data,
  output logic [1:0]      o_pc_incr_op,
  output logic [4:0]      o_rd_addr,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic            o_illegal
);

  // Major opcodes on instr[6:0]
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    TYPE_R   = 3'd0,
    TYPE_I   = 3'd1,
    TYPE_S   = 3'd2,
    TYPE_B   = 3'd3,
    TYPE_U   = 3'd4,
    TYPE_J   = 3'd5,
    TYPE_INV = 3'd7
  } instr_type_e;

  typedef enum logic [1:0] {
    PC_PLUS4    = 2'b00,
    PC_PLUS_IMM = 2'b01,
    PC_RS1_IMM  = 2'b10,
    PC_HOLD     = 2'b11
  } pc_op_e;

  typedef struct packed {
    instr_type_e     itype;
    logic [XLEN-1:0] imm;
    pc_op_e          pc_op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    S_HALT  = 2'd3
`endif
  } state_e;

  state_e          state;
  bundle_t         dec;
  bundle_t         main_q;
  bundle_t         skid_q;
  logic            ready_q;
  logic            valid_q;
  logic            in_hs;
  logic            out_hs;
  logic [XLEN-1:0] w;

  assign w      = i_instr_data;
  assign in_hs  = i_instr_valid & ready_q;
  assign out_hs = valid_q & i_dec_ready;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    dec         = '0;
    dec.itype   = TYPE_INV;
    dec.pc_op   = PC_PLUS4;
    dec.rd      = w[11:7];
    dec.rs1     = w[19:15];
    dec.rs2     = w[24:20];
    dec.funct3  = w[14:12];
    dec.funct7  = w[31:25];
    dec.illegal = 1'b0;
    case (w[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.itype = TYPE_U;
        dec.imm   = {{(XLEN-20){w[31]}}, w[31:12]} << 12;
      end
      OPC_JAL: begin
        dec.itype = TYPE_J;
        dec.imm   = {{(XLEN-20){w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        dec.pc_op = PC_PLUS_IMM;
      end
      OPC_JALR: begin
        dec.itype = TYPE_I;
        dec.imm   = {{(XLEN-12){w[31]}}, w[31:20]};
        dec.pc_op = PC_RS1_IMM;
      end
      OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: begin
        dec.itype = TYPE_I;
        dec.imm   = {{(XLEN-12){w[31]}}, w[31:20]};
      end
      OPC_STORE: begin
        dec.itype = TYPE_S;
        dec.imm   = {{(XLEN-12){w[31]}}, w[31:25], w[11:7]};
      end
      OPC_BRANCH: begin
        dec.itype = TYPE_B;
        dec.imm   = {{(XLEN-12){w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        dec.pc_op = PC_PLUS_IMM;
      end
      OPC_OP: begin
        dec.itype = TYPE_R;
      end
      default: begin
        // Unknown opcode or instr[1:0] != 2'b11: type 7, immediate 0.
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
        dec.pc_op   = PC_HOLD;
`else
        dec.pc_op   = PC_PLUS4;
`endif
      end
    endcase
  end

  // Buffer control FSM: moves bundles between input, skid and main entries
  // and registers the ready/valid handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      // NOTE: both entries are reset because main drives the outputs, which
      // must read zero during reset; skid is cleared so no stale word survives.
      state   <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          ready_q <= 1'b1;
          if (in_hs) begin
            main_q  <= dec;
            valid_q <= 1'b1;
            state   <= S_ONE;
          end
        end
        S_ONE: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
          if (out_hs && main_q.illegal) begin
            main_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            state   <= S_HALT;
          end else
`endif
          if (in_hs && out_hs) begin
            // Consumer drains main while a new word arrives: overwrite main.
            main_q <= dec;
          end else if (in_hs) begin
            // Output stalled: park the new word in skid and stop accepting.
            skid_q  <= dec;
            ready_q <= 1'b0;
            state   <= S_FULL;
          end else if (out_hs) begin
            valid_q <= 1'b0;
            state   <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_hs) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (main_q.illegal) begin
              main_q  <= '0;
              ready_q <= 1'b0;
              valid_q <= 1'b0;
              state   <= S_HALT;
            end else begin
              main_q  <= skid_q;
              ready_q <= 1'b1;
              state   <= S_ONE;
            end
`else
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state   <= S_ONE;
`endif
          end
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        S_HALT: begin
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
`endif
        default: begin
          state   <= S_EMPTY;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_instr_ready = ready_q;
  assign o_dec_valid   = valid_q;
  assign o_instr_type  = main_q.itype;
  assign o_imm_data    = main_q.imm;
  assign o_pc_incr_op  = main_q.pc_op;
  assign o_rd_addr     = main_q.rd;
  assign o_rs1_addr    = main_q.rs1;
  assign o_rs2_addr    = main_q.rs2;
  assign o_funct3      = main_q.funct3;
  assign o_funct7      = main_q.funct7;
  assign o_illegal     = main_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: directed self-checking bench for decode_unit.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_instr_valid = 1'b0;
  logic        o_instr_ready;
  logic [31:0] i_instr_data = '0;
  logic        o_dec_valid;
  logic        i_dec_ready = 1'b0;
  logic [2:0]  o_instr_type;
  logic [31:0] o_imm_data;
  logic [1:0]  o_pc_incr_op;
  logic [4:0]  o_rd_addr;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [2:0]  o_funct3;
  logic [6:0]  o_funct7;
  logic        o_illegal;

  int n_pass  = 0;
  int n_total = 0;

  decode_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_instr_data  (i_instr_data),
    .o_dec_valid   (o_dec_valid),
    .i_dec_ready   (i_dec_ready),
    .o_instr_type  (o_instr_type),
    .o_imm_data    (o_imm_data),
    .o_pc_incr_op  (o_pc_incr_op),
    .o_rd_addr     (o_rd_addr),
    .o_rs1_addr    (o_rs1_addr),
    .o_rs2_addr    (o_rs2_addr),
    .o_funct3      (o_funct3),
    .o_funct7      (o_funct7),
    .o_illegal     (o_illegal)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    i_dec_ready = 1'b1;
    i_instr_valid = 1'b1;
    i_instr_data = 32'h00500093;
    step();
    step();
    n_total++; if (o_instr_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", o_instr_ready); else n_pass++;
    n_total++; if (o_dec_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", o_dec_valid); else n_pass++;
    n_total++;
    if ({o_instr_type, o_imm_data, o_pc_incr_op, o_rd_addr, o_rs1_addr, o_rs2_addr, o_funct3, o_funct7, o_illegal} !== '0)
      $display("FAIL reset_fields: type=%0d imm=%h pc=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%0d ill=%0b want all 0",
               o_instr_type, o_imm_data, o_pc_incr_op, o_rd_addr, o_rs1_addr, o_rs2_addr, o_funct3, o_funct7, o_illegal);
    else n_pass++;
    i_instr_valid = 1'b0;
    rstn = 1'b1;
    step();
    n_total++; if (o_instr_ready !== 1'b1) $display("FAIL post_reset_ready: got %0b want 1", o_instr_ready); else n_pass++;
    n_total++; if (o_dec_valid !== 1'b0) $display("FAIL post_reset_valid: got %0b want 0", o_dec_valid); else n_pass++;
  endtask

  task automatic test_i_type();
    i_dec_ready = 1'b1;
    i_instr_valid = 1'b1;
    i_instr_data = 32'h00500093;  // ADDI x1,x0,5
    step();
    i_instr_valid = 1'b0;
    n_total++; if (o_dec_valid !== 1'b1) $display("FAIL addi_valid: got %0b want 1", o_dec_valid); else n_pass++;
    n_total++; if (o_instr_type !== 3'd1) $display("FAIL addi_type: got %0d want 1", o_instr_type); else n_pass++;
    n_total++; if (o_imm_data !== 32'h00000005) $display("FAIL addi_imm: got %h want 00000005", o_imm_data); else n_pass++;
    n_total++;
    if ({o_rd_addr, o_rs1_addr, o_funct3, o_pc_incr_op} !== {5'd1, 5'd0, 3'd0, 2'b00})
      $display("FAIL addi_fields: rd=%0d rs1=%0d f3=%0d pc=%0d want rd=1 rs1=0 f3=0 pc=0",
               o_rd_addr, o_rs1_addr, o_funct3, o_pc_incr_op);
    else n_pass++;
    step();
    n_total++; if (o_dec_valid !== 1'b0) $display("FAIL addi_drain: got %0b want 0", o_dec_valid); else n_pass++;
  endtask

  task automatic test_jal_sw();
    i_dec_ready = 1'b1;
    i_instr_valid = 1'b1;
    i_instr_data = 32'hFF9FF06F;  // JAL x0,-8
    step();
    i_instr_data = 32'h0020A623;  // SW x2,12(x1)
    n_total++;
    if ({o_dec_valid, o_instr_type, o_imm_data, o_pc_incr_op} !== {1'b1, 3'd5, 32'hFFFFFFF8, 2'b01})
      $display("FAIL jal: valid=%0b type=%0d imm=%h pc=%0d want valid=1 type=5 imm=fffffff8 pc=1",
               o_dec_valid, o_instr_type, o_imm_data, o_pc_incr_op);
    else n_pass++;
    step();
    i_instr_valid = 1'b0;
    n_total++;
    if ({o_dec_valid, o_instr_type, o_imm_data, o_pc_incr_op} !== {1'b1, 3'd2, 32'h0000000C, 2'b00})
      $display("FAIL sw: valid=%0b type=%0d imm=%h pc=%0d want valid=1 type=2 imm=0000000c pc=0",
               o_dec_valid, o_instr_type, o_imm_data, o_pc_incr_op);
    else n_pass++;
    n_total++;
    if ({o_rs1_addr, o_rs2_addr, o_funct3} !== {5'd1, 5'd2, 3'd2})
      $display("FAIL sw_fields: rs1=%0d rs2=%0d f3=%0d want rs1=1 rs2=2 f3=2", o_rs1_addr, o_rs2_addr, o_funct3);
    else n_pass++;
    step();
  endtask

  task automatic test_lui_jalr();
    i_dec_ready = 1'b1;
    i_instr_valid = 1'b1;
    i_instr_data = 32'h123452B7;  // LUI x5,0x12345
    step();
    i_instr_data = 32'h00008067;  // JALR x0,0(x1)
    n_total++;
    if ({o_instr_type, o_imm_data, o_rd_addr, o_pc_incr_op} !== {3'd4, 32'h12345000, 5'd5, 2'b00})
      $display("FAIL lui: type=%0d imm=%h rd=%0d pc=%0d want type=4 imm=12345000 rd=5 pc=0",
               o_instr_type, o_imm_data, o_rd_addr, o_pc_incr_op);
    else n_pass++;
    step();
    i_instr_valid = 1'b0;
    n_total++;
    if ({o_instr_type, o_imm_data, o_rs1_addr, o_pc_incr_op} !== {3'd1, 32'h0, 5'd1, 2'b10})
      $display("FAIL jalr: type=%0d imm=%h rs1=%0d pc=%0d want type=1 imm=0 rs1=1 pc=2",
               o_instr_type, o_imm_data, o_rs1_addr, o_pc_incr_op);
    else n_pass++;
    step();
  endtask

  // Words carry immediates 1..4 so delivery order is visible on o_imm_data.
  task automatic test_back_to_back();
    i_dec_ready = 1'b1;
    i_instr_valid = 1'b1;
    i_instr_data = 32'h00100093;  // cycle 1: A
    step();
    i_dec_ready = 1'b0;           // cycle 2: B offered, sink stalls
    i_instr_data = 32'h00200113;
    step();
    i_instr_data = 32'h00300193;  // cycle 3: C offered, must be refused
    n_total++; if (o_instr_ready !== 1'b0) $display("FAIL b2b_ready_c3: got %0b want 0", o_instr_ready); else n_pass++;
    n_total++;
    if ({o_dec_valid, o_imm_data} !== {1'b1, 32'd1})
      $display("FAIL b2b_hold_c3: valid=%0b imm=%h want valid=1 imm=00000001", o_dec_valid, o_imm_data);
    else n_pass++;
    step();
    n_total++; if (o_instr_ready !== 1'b0) $display("FAIL b2b_ready_c4: got %0b want 0", o_instr_ready); else n_pass++;
    n_total++; if (o_imm_data !== 32'd1) $display("FAIL b2b_hold_c4: got %h want 00000001", o_imm_data); else n_pass++;
    step();
    i_dec_ready = 1'b1;           // cycle 5: sink returns
    step();                       // A delivered, B moves to main
    n_total++;
    if ({o_dec_valid, o_imm_data, o_instr_ready} !== {1'b1, 32'd2, 1'b1})
      $display("FAIL b2b_b: valid=%0b imm=%h ready=%0b want valid=1 imm=00000002 ready=1",
               o_dec_valid, o_imm_data, o_instr_ready);
    else n_pass++;
    step();                       // C accepted while B delivered
    i_instr_data = 32'h00400213;
    n_total++; if (o_imm_data !== 32'd3) $display("FAIL b2b_c: got %h want 00000003", o_imm_data); else n_pass++;
    step();
    i_instr_valid = 1'b0;
    n_total++;
    if ({o_dec_valid, o_imm_data, o_rd_addr} !== {1'b1, 32'd4, 5'd4})
      $display("FAIL b2b_d: valid=%0b imm=%h rd=%0d want valid=1 imm=00000004 rd=4", o_dec_valid, o_imm_data, o_rd_addr);
    else n_pass++;
    step();
    n_total++; if (o_dec_valid !== 1'b0) $display("FAIL b2b_drain: got %0b want 0", o_dec_valid); else n_pass++;
  endtask

  task automatic test_illegal();
    i_dec_ready = 1'b1;
    i_instr_valid = 1'b1;
    i_instr_data = 32'hFFFFFFFF;
    step();
`ifdef DECODE_ILLEGAL_TRAP_EN
    i_instr_valid = 1'b0;
    n_total++;
    if ({o_dec_valid, o_illegal, o_pc_incr_op, o_instr_type} !== {1'b1, 1'b1, 2'b11, 3'd7})
      $display("FAIL illegal_trap: valid=%0b ill=%0b pc=%0d type=%0d want valid=1 ill=1 pc=3 type=7",
               o_dec_valid, o_illegal, o_pc_incr_op, o_instr_type);
    else n_pass++;
    step();
    i_instr_valid = 1'b1;
    i_instr_data = 32'h00500093;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({o_instr_ready, o_dec_valid} !== 2'b00)
        $display("FAIL illegal_halt[%0d]: ready=%0b valid=%0b want 0 0", i, o_instr_ready, o_dec_valid);
      else n_pass++;
      step();
    end
    i_instr_valid = 1'b0;
`else
    i_instr_data = 32'h00500093;
    n_total++;
    if ({o_dec_valid, o_instr_type, o_imm_data, o_pc_incr_op, o_illegal} !== {1'b1, 3'd7, 32'h0, 2'b00, 1'b0})
      $display("FAIL illegal_nop: valid=%0b type=%0d imm=%h pc=%0d ill=%0b want valid=1 type=7 imm=0 pc=0 ill=0",
               o_dec_valid, o_instr_type, o_imm_data, o_pc_incr_op, o_illegal);
    else n_pass++;
    step();
    i_instr_valid = 1'b0;
    n_total++;
    if ({o_dec_valid, o_instr_type, o_imm_data} !== {1'b1, 3'd1, 32'd5})
      $display("FAIL illegal_continue: valid=%0b type=%0d imm=%h want valid=1 type=1 imm=00000005",
               o_dec_valid, o_instr_type, o_imm_data);
    else n_pass++;
    step();
`endif
  endtask

  task automatic test_reset_full();
    rstn = 1'b0;                  // clean start (also leaves any halt)
    i_instr_valid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    i_dec_ready = 1'b0;
    i_instr_valid = 1'b1;
    i_instr_data = 32'h00500093;
    step();
    i_instr_data = 32'h123452B7;
    step();
    i_instr_valid = 1'b0;
    n_total++;
    if ({o_instr_ready, o_dec_valid} !== 2'b01)
      $display("FAIL full_state: ready=%0b valid=%0b want ready=0 valid=1", o_instr_ready, o_dec_valid);
    else n_pass++;
    rstn = 1'b0;
    step();
    n_total++;
    if ({o_instr_ready, o_dec_valid, o_imm_data} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL full_reset: ready=%0b valid=%0b imm=%h want 0 0 0", o_instr_ready, o_dec_valid, o_imm_data);
    else n_pass++;
    rstn = 1'b1;
    i_dec_ready = 1'b1;
    step();
    n_total++;
    if ({o_instr_ready, o_dec_valid} !== 2'b10)
      $display("FAIL full_release: ready=%0b valid=%0b want ready=1 valid=0", o_instr_ready, o_dec_valid);
    else n_pass++;
    step();
    n_total++; if (o_dec_valid !== 1'b0) $display("FAIL full_no_stale: got %0b want 0", o_dec_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_jal_sw();
    test_lui_jalr();
    test_back_to_back();
    test_illegal();
    test_reset_full();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
